// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg: shared CPU word, RAM handshake and arbiter state types
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_wait_timer.sv
// ============================================================================
// arb_wait_timer: saturating grant wait counter with clear and TIMEOUT compare
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the cycle whose edge completes the TIMEOUT-th wait cycle.
  assign expired_o = inc_i && (count_q >= LAST);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter: single-port RAM arbiter between instruction fetch and data access
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT     = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      ihit,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state_q, state_d;
  word_t         addr_q, addr_d, store_q, store_d;
  word_t         iload_q, iload_d, dload_q, dload_d;
  logic          wen_q, wen_d, ihit_q, ihit_d, dhit_q, dhit_d;
  logic          memerr_q, memerr_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          in_grant, dreq, wait_clr, wait_inc, wait_expired;

  assign in_grant = (state_q == IGRANT) || (state_q == DGRANT);
  assign dreq     = dREN | dWEN;
  assign wait_inc = in_grant && (ramstate != ACCESS);

  arb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .CLK       (CLK),
    .RST       (RST),
    .clr_i     (wait_clr),
    .inc_i     (wait_inc),
    .expired_o (wait_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wen_d     = wen_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    memerr_d  = memerr_q;
    dstreak_d = dstreak_q;
    ihit_d    = 1'b0;
    dhit_d    = 1'b0;
    wait_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq || iREN) begin
          wait_clr = 1'b1;
          if (dreq && !(iREN && (dstreak_q == STREAK_MAX))) begin
            state_d   = DGRANT;
            addr_d    = daddr;
            store_d   = dstore;
            wen_d     = dWEN;
            dstreak_d = iREN ? dstreak_q + SW'(1) : '0;
          end else begin
            state_d   = IGRANT;
            addr_d    = iaddr;
            store_d   = '0;
            wen_d     = 1'b0;
            dstreak_d = '0;
          end
        end
      end
      IGRANT, DGRANT: begin
        if ((ramstate == ACCESS) || (ramstate == ERROR) || wait_expired) begin
          state_d = DONE;
          ihit_d  = (state_q == IGRANT);
          dhit_d  = (state_q == DGRANT);
          // An aborted write leaves dload alone, like a completed one.
          if (state_q == IGRANT) begin
            iload_d = (ramstate == ACCESS) ? ramload : '0;
          end else if (!wen_q) begin
            dload_d = (ramstate == ACCESS) ? ramload : '0;
          end
          if (ramstate != ACCESS) begin
            memerr_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      wen_q     <= 1'b0;
      iload_q   <= '0;
      dload_q   <= '0;
      ihit_q    <= 1'b0;
      dhit_q    <= 1'b0;
      memerr_q  <= 1'b0;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      wen_q     <= wen_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      ihit_q    <= ihit_d;
      dhit_q    <= dhit_d;
      memerr_q  <= memerr_d;
      dstreak_q <= dstreak_d;
    end
  end

  // RAM side sees only the latched request, never the live requester inputs.
  assign ramREN   = in_grant & ~wen_q;
  assign ramWEN   = in_grant & wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign memerr   = memerr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter: randomized self-checking bench with RAM and reference models
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT     = 16;
  localparam int MAX_DSTREAK = 4;

  logic      CLK = 1'b0;
  logic      RST = 1'b1;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic      ihit, dhit, ramREN, ramWEN, memerr;
  word_t     iload, dload, ramaddr, ramstore;

  mem_arbiter #(
    .TIMEOUT     (TIMEOUT),
    .MAX_DSTREAK (MAX_DSTREAK)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .ihit     (ihit),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .memerr   (memerr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // RAM model: answers ACCESS after ram_lat wait cycles (never if negative).
  word_t ram_mem [word_t];
  int    ram_lat  = 0;
  bit    ram_err  = 1'b0;
  int    busy_cnt = 0;

  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      ramload = $urandom;
      if (ram_err) begin
        ramstate = ERROR;
      end else if (ram_lat >= 0 && busy_cnt == ram_lat) begin
        ramstate = ACCESS;
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        else        ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : '0;
      end else begin
        ramstate = BUSY;
      end
      busy_cnt++;
    end else begin
      busy_cnt = 0;
      ramstate = FREE;
      ramload  = $urandom;
    end
  end

  // Reference model state, transaction level.
  word_t ref_mem [word_t];
  int    streak = 0;
  word_t exp_iload = '0, exp_dload = '0;
  bit    exp_memerr = 1'b0;

  task automatic txn(input bit ir, input bit dr, input bit dw,
                     input word_t ia, input word_t da, input word_t ds,
                     input int lat, input bit err, input bit hold);
    bit    dside, wr, abort;
    int    exp_hit, hit_c;
    word_t a, rd;
    dside = (dr || dw) && !(ir && streak == MAX_DSTREAK);
    if (dside) streak = ir ? streak + 1 : 0;
    else       streak = 0;
    wr = dside && dw;
    a  = dside ? da : ia;
    if (err) begin
      abort = 1'b1; exp_hit = 2;
    end else if (lat < 0 || lat >= TIMEOUT) begin
      abort = 1'b1; exp_hit = TIMEOUT + 1;
    end else begin
      abort = 1'b0; exp_hit = 2 + lat;
    end
    rd = abort ? '0 : (ref_mem.exists(a) ? ref_mem[a] : '0);
    if (abort)   exp_memerr = 1'b1;
    else if (wr) ref_mem[a] = ds;
    if (!dside)   exp_iload = rd;
    else if (!wr) exp_dload = rd;

    ram_lat = lat;
    ram_err = err;
    @(posedge CLK); #1;
    iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    hit_c = 0;
    for (int c = 1; c <= TIMEOUT + 8 && hit_c == 0; c++) begin
      @(posedge CLK); #1;
      if (c == 1 && !hold) begin
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = $urandom; daddr = $urandom; dstore = $urandom;
      end
      @(negedge CLK);
      if (ihit || dhit) begin
        hit_c = c;
      end else begin
        check_eq("grant_ramREN", 32'(ramREN), 32'(!wr));
        check_eq("grant_ramWEN", 32'(ramWEN), 32'(wr));
        check_eq("grant_ramaddr", ramaddr, a);
        if (wr) check_eq("grant_ramstore", ramstore, ds);
      end
    end
    check_eq("hit_cycle", word_t'(hit_c), word_t'(exp_hit));
    if (hit_c != 0) begin
      check_eq("ihit", 32'(ihit), 32'(!dside));
      check_eq("dhit", 32'(dhit), 32'(dside));
      check_eq("iload", iload, exp_iload);
      check_eq("dload", dload, exp_dload);
      check_eq("memerr", 32'(memerr), 32'(exp_memerr));
      check_eq("done_strobes", 32'(ramREN | ramWEN), 32'(0));
    end
  endtask

  task automatic idle_cycles(input int n);
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (n) @(posedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ihit"},     32'(ihit),     32'(0));
    check_eq({tag, "_dhit"},     32'(dhit),     32'(0));
    check_eq({tag, "_ramREN"},   32'(ramREN),   32'(0));
    check_eq({tag, "_ramWEN"},   32'(ramWEN),   32'(0));
    check_eq({tag, "_memerr"},   32'(memerr),   32'(0));
    check_eq({tag, "_ramaddr"},  ramaddr,       32'(0));
    check_eq({tag, "_ramstore"}, ramstore,      32'(0));
    check_eq({tag, "_iload"},    iload,         32'(0));
    check_eq({tag, "_dload"},    dload,         32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    word_t addrs [4];
    bit    ir, dr, dw, err, hold;
    int    lat;
    addrs = '{32'h0000_0040, 32'h0000_0080, 32'h0000_0100, 32'h0000_0104};

    ram_mem[32'h0000_0040] = 32'h2001_0005;
    ref_mem[32'h0000_0040] = 32'h2001_0005;
    ram_mem[32'h0000_0100] = 32'h1234_5678;
    ref_mem[32'h0000_0100] = 32'h1234_5678;

    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    // Isolated fetch, zero wait
    txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, 1);
    // Simultaneous fetch and data read, data first, then fetch
    txn(1, 1, 0, 32'h40, 32'h100, 32'h0, 3, 0, 1);
    txn(1, 0, 0, 32'h40, 32'h100, 32'h0, 3, 0, 1);
    // Data write stream with fetch held: fetch wins every fifth grant
    for (int k = 0; k < 10; k++)
      txn(1, 0, 1, 32'h40, 32'h200 + 32'(4 * k), 32'hA000_0000 + 32'(k), 0, 0, 1);
    // Write then read back
    idle_cycles(2);
    txn(0, 0, 1, 32'h0, 32'h80, 32'hDEAD_BEEF, 2, 0, 1);
    idle_cycles(1);
    txn(0, 1, 0, 32'h0, 32'h80, 32'h0, 1, 0, 1);
    // RAM stuck busy: timeout abort, then normal service with sticky memerr
    txn(0, 1, 0, 32'h0, 32'h80, 32'h0, -1, 0, 1);
    txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, 1);
    // RAM error response
    txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 1, 1);

    for (int n = 0; n < 50; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      if (!(ir || dr || dw)) ir = 1'b1;
      lat  = $urandom_range(0, 4);
      if ($urandom_range(0, 14) == 0) lat = -1;
      err  = ($urandom_range(0, 11) == 0);
      hold = ($urandom_range(0, 3) != 0);
      txn(ir, dr, dw, addrs[$urandom_range(0, 3)], addrs[$urandom_range(0, 3)],
          $urandom, lat, err, hold);
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
    end

    // Reset in the middle of a busy data grant
    ram_lat = -1;
    ram_err = 1'b0;
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h80;
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("rst_pre_ramREN", 32'(ramREN), 32'(1));
    @(posedge CLK); #1;
    RST = 1'b1; dREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    @(posedge CLK);
    @(negedge CLK);
    check_eq("midrst_no_dhit", 32'(dhit), 32'(0));
    check_eq("midrst_no_ren",  32'(ramREN), 32'(0));
    streak     = 0;
    exp_iload  = '0;
    exp_dload  = '0;
    exp_memerr = 1'b0;
    txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
